// File: rtl/alu_acc_if.sv
// Operand/result bus between operand mux B, the control sequencer and the accumulator stage.
// slave = accumulator side, master = the block that issues operations.
interface alu_acc_if #(
  parameter int DATA_WIDTH = 11
) ();
  logic [DATA_WIDTH-1:0] mux_B_in;
  logic [2:0]            op_sel;
  logic                  op_valid;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] acc_out;
  logic                  zero_flag;
  logic                  negative_flag;
  logic                  carry_flag;

  modport master (
    output mux_B_in, op_sel, op_valid,
    input  busy, done, acc_out, zero_flag, negative_flag, carry_flag
  );

  modport slave (
    input  mux_B_in, op_sel, op_valid,
    output busy, done, acc_out, zero_flag, negative_flag, carry_flag
  );
endinterface

// File: rtl/alu_acc.sv
// Accumulator stage behind operand mux B: single-cycle LDA/ADD/SUB/AND/OR/XOR/NOT and an
// optional shift-add multiply built only when ALU_ACC_MUL_EN is defined (otherwise op 7 is a NOP).
module alu_acc #(
  parameter int DATA_WIDTH = 11
) (
  input logic       clk,
  input logic       reset,
  alu_acc_if.slave  bus
);
  localparam logic [2:0] OP_LDA = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_NOT = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic [1:0] {IDLE, MUL, FIN} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] acc;
  logic                  carry;
  logic                  busy_q;
  logic                  done_q;

  // Both arithmetic results are one bit wider so the top bit is the carry / not-borrow.
  logic [DATA_WIDTH:0]   sum_add;
  logic [DATA_WIDTH:0]   sum_sub;

  assign sum_add = {1'b0, acc} + {1'b0, bus.mux_B_in};
  assign sum_sub = {1'b0, acc} + {1'b0, ~bus.mux_B_in} + {{DATA_WIDTH{1'b0}}, 1'b1};

`ifdef ALU_ACC_MUL_EN
  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [DATA_WIDTH-1:0] mcand;
  logic [DATA_WIDTH-1:0] mplr;
  logic [DATA_WIDTH-1:0] partial;
  logic [DATA_WIDTH-1:0] partial_nxt;
  logic [CW-1:0]         cnt;

  // Only the low DATA_WIDTH product bits are kept, so the partial sum never needs widening.
  assign partial_nxt = partial + (mplr[0] ? mcand : '0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      acc    <= '0;
      carry  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef ALU_ACC_MUL_EN
      mcand   <= '0;
      mplr    <= '0;
      partial <= '0;
      cnt     <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.op_valid) begin
            state  <= FIN;
            done_q <= 1'b1;
            case (bus.op_sel)
              OP_LDA: acc <= bus.mux_B_in;
              OP_ADD: {carry, acc} <= sum_add;
              OP_SUB: {carry, acc} <= sum_sub;
              OP_AND: acc <= acc & bus.mux_B_in;
              OP_OR:  acc <= acc | bus.mux_B_in;
              OP_XOR: acc <= acc ^ bus.mux_B_in;
              OP_NOT: acc <= ~acc;
              OP_MUL: begin
`ifdef ALU_ACC_MUL_EN
                state   <= MUL;
                done_q  <= 1'b0;
                busy_q  <= 1'b1;
                mcand   <= acc;
                mplr    <= bus.mux_B_in;
                partial <= '0;
                cnt     <= '0;
`endif
              end
              default: ;
            endcase
          end
        end
        MUL: begin
`ifdef ALU_ACC_MUL_EN
          partial <= partial_nxt;
          mcand   <= mcand << 1;
          mplr    <= mplr >> 1;
          cnt     <= cnt + CW'(1);
          if (cnt == CW'(DATA_WIDTH - 1)) begin
            acc    <= partial_nxt;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= FIN;
          end
`else
          state <= IDLE;
`endif
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.acc_out       = acc;
  assign bus.zero_flag     = (acc == '0);
  assign bus.negative_flag = acc[DATA_WIDTH-1];
  assign bus.carry_flag    = carry;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
endmodule
